exc_redirect: RTL and testbench



---
 rtl/exc_redirect_if.sv | 33 +++
 rtl/exc_redirect.sv | 176 +++++++++++++++++
 tb/tb_exc_redirect.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/exc_redirect_if.sv
// Fetch-side redirect interface: the flush/hold/drop controls and the
// redirect PC valid/ready handshake between exc_redirect and the fetch stage.
interface exc_redirect_if;
    logic        flush;
    logic        fe_hold;
    logic        drop_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_busy;
    logic        redirect_ready;

    // Exception/redirect controller side
    modport master (
        output flush,
        output fe_hold,
        output drop_resp,
        output redirect_valid,
        output redirect_pc,
        input  if_busy,
        input  redirect_ready
    );

    // Fetch stage side
    modport slave (
        input  flush,
        input  fe_hold,
        input  drop_resp,
        input  redirect_valid,
        input  redirect_pc,
        output if_busy,
        output redirect_ready
    );
endinterface

// File: rtl/exc_redirect.sv
// Consumes CP0 exception/ERET outputs: flushes the pipeline, drains any
// outstanding instruction fetch, then hands fetch a redirect PC through a
// valid/ready handshake. Also keeps saturating exception/ERET counters.
module exc_redirect #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter int          DRAIN_TIMEOUT = 16,
    parameter int          CNT_W         = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stall_i,
    input  logic               excep_i,
    input  logic               eret_i,
    input  logic [31:0]        epc_i,
    exc_redirect_if.master     fe,
    output logic               busy_o,
    output logic               drain_err_o,
    output logic [CNT_W-1:0]   exc_cnt_o,
    output logic [CNT_W-1:0]   eret_cnt_o
);

    localparam int            TW     = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef enum logic {
        KIND_EXC  = 1'b0,
        KIND_ERET = 1'b1
    } kind_t;

    state_t            state_q,     state_d;
    kind_t             kind_q,      kind_d;
    logic [31:0]       target_q,    target_d;
    logic [TW-1:0]     tcnt_q,      tcnt_d;
    logic              drain_err_q, drain_err_d;
    logic [CNT_W-1:0]  exc_cnt_q,   exc_cnt_d;
    logic [CNT_W-1:0]  eret_cnt_q,  eret_cnt_d;

    logic flush_c;
    logic fe_hold_c;
    logic drop_resp_c;
    logic redirect_valid_c;
    logic busy_c;
    logic accept_c;
    logic retarget_c;

    // An event is taken only from IDLE and only while the pipeline is not
    // stalled; an exception arriving while an ERET return is in flight
    // overrides the return target (interrupt during ERET).
    always_comb begin
        accept_c   = (state_q == IDLE) && !stall_i && (excep_i || eret_i);
        retarget_c = (state_q != IDLE) && excep_i && (kind_q == KIND_ERET);
    end

    // Next-state, datapath and output decode for the redirect FSM.
    // A retarget keeps the current state for that cycle so that the
    // exception vector is always presented on a later handshake, even if
    // fetch happened to accept the stale ERET target in the same cycle.
    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        target_d         = target_q;
        tcnt_d           = tcnt_q;
        drain_err_d      = drain_err_q;
        exc_cnt_d        = exc_cnt_q;
        eret_cnt_d       = eret_cnt_q;
        flush_c          = 1'b0;
        fe_hold_c        = 1'b0;
        drop_resp_c      = 1'b0;
        redirect_valid_c = 1'b0;
        busy_c           = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    flush_c = 1'b1;
                    tcnt_d  = '0;
                    if (excep_i) begin
                        kind_d   = KIND_EXC;
                        target_d = EXC_VECTOR;
                        if (!(&exc_cnt_q)) begin
                            exc_cnt_d = exc_cnt_q + 1'b1;
                        end
                    end else begin
                        kind_d   = KIND_ERET;
                        target_d = epc_i;
                        if (!(&eret_cnt_q)) begin
                            eret_cnt_d = eret_cnt_q + 1'b1;
                        end
                    end
                    state_d = fe.if_busy ? DRAIN : REDIRECT;
                end
            end

            DRAIN: begin
                fe_hold_c   = 1'b1;
                drop_resp_c = 1'b1;
                busy_c      = 1'b1;
                if (tcnt_q != T_MAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (retarget_c) begin
                    flush_c  = 1'b1;
                    kind_d   = KIND_EXC;
                    target_d = EXC_VECTOR;
                    if (!(&exc_cnt_q)) begin
                        exc_cnt_d = exc_cnt_q + 1'b1;
                    end
                end else if (!fe.if_busy) begin
                    state_d = REDIRECT;
                end else if (tcnt_q >= T_LAST) begin
                    state_d     = REDIRECT;
                    drain_err_d = 1'b1;
                end
            end

            REDIRECT: begin
                redirect_valid_c = 1'b1;
                fe_hold_c        = 1'b1;
                busy_c           = 1'b1;
                if (retarget_c) begin
                    flush_c  = 1'b1;
                    kind_d   = KIND_EXC;
                    target_d = EXC_VECTOR;
                    if (!(&exc_cnt_q)) begin
                        exc_cnt_d = exc_cnt_q + 1'b1;
                    end
                end else if (fe.redirect_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            kind_q      <= KIND_EXC;
            target_q    <= '0;
            tcnt_q      <= '0;
            drain_err_q <= 1'b0;
            exc_cnt_q   <= '0;
            eret_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            target_q    <= target_d;
            tcnt_q      <= tcnt_d;
            drain_err_q <= drain_err_d;
            exc_cnt_q   <= exc_cnt_d;
            eret_cnt_q  <= eret_cnt_d;
        end
    end

    assign fe.flush          = flush_c;
    assign fe.fe_hold        = fe_hold_c;
    assign fe.drop_resp      = drop_resp_c;
    assign fe.redirect_valid = redirect_valid_c;
    assign fe.redirect_pc    = target_q;
    assign busy_o            = busy_c;
    assign drain_err_o       = drain_err_q;
    assign exc_cnt_o         = exc_cnt_q;
    assign eret_cnt_o        = eret_cnt_q;

endmodule

// File: tb/tb_exc_redirect.sv
// Self-checking bench for exc_redirect: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_exc_redirect;

    localparam logic [31:0] VEC     = 32'hBFC00380;
    localparam int          TIMEOUT = 16;
    localparam int          CNTMAX  = 65535;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        excep;
    logic        eret;
    logic [31:0] epc;
    logic        busy;
    logic        drainErr;
    logic [15:0] excCnt;
    logic [15:0] eretCnt;

    exc_redirect_if fe ();

    exc_redirect #(
        .EXC_VECTOR    (VEC),
        .DRAIN_TIMEOUT (TIMEOUT),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stall_i     (stall),
        .excep_i     (excep),
        .eret_i      (eret),
        .epc_i       (epc),
        .fe          (fe),
        .busy_o      (busy),
        .drain_err_o (drainErr),
        .exc_cnt_o   (excCnt),
        .eret_cnt_o  (eretCnt)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Transaction-level model: is a redirect in flight, is it still waiting
    // for fetch to go quiet, how long has it waited, and where is it going.
    bit          mInFlight   = 0;
    bit          mWaiting    = 0;
    int          mWaitCycles = 0;
    logic [31:0] mTarget     = 0;
    bit          mFromEret   = 0;
    bit          mErr        = 0;
    int          mExc        = 0;
    int          mEret       = 0;
    int          redirectsSeen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=%h expected=%h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then
    // advance the model by the edge that will consume these inputs.
    task automatic applyStimulus(input bit rn, input bit st, input bit ex,
                                 input bit er, input logic [31:0] pc,
                                 input bit ib, input bit rdy);
        bit takeEvent;
        bit override;
        @(negedge clk);
        resetn = rn;
        stall  = st;
        excep  = ex;
        eret   = er;
        epc    = pc;
        fe.if_busy        = ib;
        fe.redirect_ready = rdy;
        #1;
        takeEvent = !mInFlight && !st && (ex || er);
        override  = mInFlight && ex && mFromEret;

        checkOutput("flush",     {31'd0, fe.flush},          {31'd0, takeEvent || override});
        checkOutput("fe_hold",   {31'd0, fe.fe_hold},        {31'd0, mInFlight});
        checkOutput("drop_resp", {31'd0, fe.drop_resp},      {31'd0, mInFlight && mWaiting});
        checkOutput("rvalid",    {31'd0, fe.redirect_valid}, {31'd0, mInFlight && !mWaiting});
        checkOutput("rpc",       fe.redirect_pc,             mTarget);
        checkOutput("busy",      {31'd0, busy},              {31'd0, mInFlight});
        checkOutput("drain_err", {31'd0, drainErr},          {31'd0, mErr});
        checkOutput("exc_cnt",   {16'd0, excCnt},            mExc);
        checkOutput("eret_cnt",  {16'd0, eretCnt},           mEret);

        if (!rn) begin
            mInFlight = 0; mWaiting = 0; mWaitCycles = 0; mTarget = 0;
            mFromEret = 0; mErr = 0; mExc = 0; mEret = 0;
        end else if (takeEvent) begin
            if (ex) begin
                mTarget = VEC; mFromEret = 0;
                if (mExc < CNTMAX) mExc++;
            end else begin
                mTarget = pc; mFromEret = 1;
                if (mEret < CNTMAX) mEret++;
            end
            mInFlight   = 1;
            mWaiting    = ib;
            mWaitCycles = 0;
        end else if (mInFlight) begin
            if (mWaiting) mWaitCycles++;
            if (override) begin
                mTarget = VEC; mFromEret = 0;
                if (mExc < CNTMAX) mExc++;
            end else if (mWaiting) begin
                if (!ib) begin
                    mWaiting = 0;
                end else if (mWaitCycles >= TIMEOUT) begin
                    mWaiting = 0;
                    mErr     = 1;
                end
            end else if (rdy) begin
                mInFlight = 0;
                redirectsSeen++;
            end
        end
    endtask

    initial begin
        int redirectsAtReset;
        int stuckLeft;
        bit ib;
        resetn = 1'b0; stall = 1'b0; excep = 1'b0; eret = 1'b0; epc = '0;
        fe.if_busy = 1'b0; fe.redirect_ready = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 0);

        // Plain exception, fetch idle, ready tied high
        applyStimulus(1, 0, 1, 0, 32'h0, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);

        // ERET with fetch busy for three cycles
        applyStimulus(1, 0, 0, 1, 32'h80001234, 1, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);

        // Simultaneous excep/eret, then excep under stall
        applyStimulus(1, 0, 1, 1, 32'h12345678, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(1, 1, 1, 0, 32'h0, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);

        // ERET held in REDIRECT, exception overrides it
        applyStimulus(1, 0, 0, 1, 32'h80004000, 0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 1, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);

        // Fetch stuck busy: forced redirect and sticky drain_err
        applyStimulus(1, 0, 1, 0, 32'h0, 1, 1);
        for (int i = 0; i < TIMEOUT + 2; i++) applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        applyStimulus(1, 0, 0, 1, 32'h80008000, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);

        // Reset during DRAIN never lets a redirect out
        redirectsAtReset = redirectsSeen;
        applyStimulus(1, 0, 1, 0, 32'h0, 1, 1);
        applyStimulus(1, 0, 0, 0, 32'h0, 1, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 32'h0, 0, 1);
        checkOutput("no_redirect_after_reset", redirectsSeen, redirectsAtReset);

        // Randomized traffic
        stuckLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            if (stuckLeft == 0 && $urandom_range(0, 199) == 0) stuckLeft = 20 + $urandom_range(0, 10);
            if (stuckLeft > 0) begin
                ib = 1;
                stuckLeft--;
            end else begin
                ib = ($urandom_range(0, 9) < 6);
            end
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 6) == 0,
                          $urandom,
                          ib,
                          $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
